// File: rtl/fb_tile_blitter.sv
// Tile blitter: copies an 8x8 or 16x16 sprite from a synchronous sprite ROM into
// the 256-wide framebuffer, skipping transparent (index 0) and off-screen pixels.
module fb_tile_blitter #(
  parameter int FB_HEIGHT = 240,
  parameter int DATA_W    = 4
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              Draw_FB_EN,
  input  logic              is_8,
  input  logic [7:0]        NewDrawX,
  input  logic [7:0]        NewDrawY,
  input  logic [6:0]        NewSpriteX,
  input  logic [6:0]        NewSpriteY,
  output logic [13:0]       rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              fb_we,
  output logic [15:0]       fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              Done_Draw_FB
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [8:0] FB_H = 9'(FB_HEIGHT);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       cnt_last;

  logic       is8_q;
  logic [7:0] draw_x_q, draw_y_q;
  logic [6:0] spr_x_q, spr_y_q;

  logic [3:0] dx, dy;
  logic [6:0] sx, sy;
  logic [8:0] fx_p0, fy_p0;

  logic       vld_p1;
  logic [8:0] fx_p1, fy_p1;

  // fx is 9 bits so a tile hanging past column 255 is clipped instead of wrapping.
  function automatic logic on_screen(input logic fx_msb, input logic [8:0] fy);
    return (fx_msb == 1'b0) && (fy < FB_H);
  endfunction

  // Stage p0: pixel issue, ROM address and framebuffer coordinates
  always_comb begin
    dx       = is8_q ? {1'b0, cnt[2:0]} : cnt[3:0];
    dy       = is8_q ? {1'b0, cnt[5:3]} : cnt[7:4];
    sx       = spr_x_q + {3'b000, dx};
    sy       = spr_y_q + {3'b000, dy};
    fx_p0    = {1'b0, draw_x_q} + {5'b00000, dx};
    fy_p0    = {1'b0, draw_y_q} + {5'b00000, dy};
    cnt_last = is8_q ? (cnt == 8'd63) : (cnt == 8'd255);
  end

  assign rom_addr = (state == READ) ? {sy, sx} : 14'd0;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (Draw_FB_EN) begin
        state_nx = READ;
        cnt_nx   = 8'd0;
      end
      READ: begin
        cnt_nx = cnt + 8'd1;
        if (cnt_last) state_nx = DRAIN;
      end
      DRAIN:   state_nx = DONE;
      DONE:    if (!Draw_FB_EN) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      vld_p1 <= (state == READ);
    end
  end

  // Stage p1: coordinates wait one cycle for the ROM read data
  always_ff @(posedge Clk) begin
    if (state == IDLE && Draw_FB_EN) begin
      is8_q    <= is_8;
      draw_x_q <= NewDrawX;
      draw_y_q <= NewDrawY;
      spr_x_q  <= NewSpriteX;
      spr_y_q  <= NewSpriteY;
    end
    fx_p1 <= fx_p0;
    fy_p1 <= fy_p0;
  end

  assign fb_we        = vld_p1 && (rom_data != '0) && on_screen(fx_p1[8], fy_p1);
  assign fb_addr      = vld_p1 ? {fy_p1[7:0], fx_p1[7:0]} : 16'd0;
  assign fb_data      = rom_data;
  assign Done_Draw_FB = (state == DONE);

endmodule

// File: tb/tb_fb_tile_blitter.sv
// Directed bench for fb_tile_blitter: ROM model, write logger and per-scenario tasks.
module tb_fb_tile_blitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        s8;
  logic [7:0]  draw_x, draw_y;
  logic [6:0]  spr_x, spr_y;
  logic [13:0] rom_addr;
  logic [3:0]  rom_data;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [3:0]  fb_data;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int e0;
  int rom_mode = 0;

  int          wr_cyc[$];
  logic [15:0] wr_addr[$];
  logic [3:0]  wr_data[$];

  fb_tile_blitter #(.FB_HEIGHT(240)) dut (
    .Clk(clk), .RESET(rst), .Draw_FB_EN(en), .is_8(s8),
    .NewDrawX(draw_x), .NewDrawY(draw_y), .NewSpriteX(spr_x), .NewSpriteY(spr_y),
    .rom_addr(rom_addr), .rom_data(rom_data), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .Done_Draw_FB(done)
  );

  always #5 clk = ~clk;

  // Sprite-sheet contents: 0 = solid 5, 1 = 0 on even sx else 9, 2 = address hash (never 0)
  function automatic logic [3:0] rom_val(input logic [13:0] a, input int mode);
    int v;
    if (mode == 0) return 4'd5;
    if (mode == 1) return a[0] ? 4'd9 : 4'd0;
    v = ((int'(a) ^ (int'(a) >> 5)) % 15) + 1;
    return 4'(v);
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_data <= rom_val(rom_addr, rom_mode);
  end

  always @(negedge clk) begin
    if (fb_we) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(fb_addr);
      wr_data.push_back(fb_data);
    end
  end

  task automatic start_tile(input logic t8, input logic [7:0] x, input logic [7:0] y,
                            input logic [6:0] sxi, input logic [6:0] syi);
    @(negedge clk);
    s8 = t8; draw_x = x; draw_y = y; spr_x = sxi; spr_y = syi; en = 1'b1;
    e0 = cyc;
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin dc = cyc; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", fb_we); end
    n_checks++; if (rom_addr !== 14'd0) begin n_fail++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
    n_checks++; if (fb_addr !== 16'd0) begin n_fail++; $display("FAIL reset_fb_addr got %0d want 0", fb_addr); end
    rst = 1'b0;
  endtask

  task automatic test_opaque_8x8;
    int dc;
    rom_mode = 0;
    start_tile(1'b1, 8'd0, 8'd0, 7'd0, 7'd0);
    wait_done(dc);
    n_checks++; if (dc !== e0 + 66) begin n_fail++; $display("FAIL op8_done_cycle got %0d want %0d", dc - e0, 66); end
    n_checks++; if (wr_addr.size() !== 64) begin n_fail++; $display("FAIL op8_count got %0d want 64", wr_addr.size()); end
    for (int k = 0; k < wr_addr.size() && k < 64; k++) begin
      n_checks++;
      if (wr_addr[k] !== 16'((k / 8) * 256 + (k % 8)) || wr_data[k] !== 4'd5 || wr_cyc[k] !== e0 + 2 + k) begin
        n_fail++;
        $display("FAIL op8_write%0d got addr %0d data %0d cyc %0d want addr %0d data 5 cyc %0d",
                 k, wr_addr[k], wr_data[k], wr_cyc[k] - e0, (k / 8) * 256 + (k % 8), 2 + k);
      end
    end
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL op8_done_fall got %b want 0", done); end
  endtask

  task automatic test_offset_16x16;
    int dc, dxk, dyk;
    rom_mode = 2;
    start_tile(1'b0, 8'd16, 8'd32, 7'd32, 7'd16);
    @(negedge clk);
    n_checks++; if (rom_addr !== 14'd2080) begin n_fail++; $display("FAIL o16_first_rom got %0d want 2080", rom_addr); end
    wait_done(dc);
    n_checks++; if (dc !== e0 + 258) begin n_fail++; $display("FAIL o16_done_cycle got %0d want 258", dc - e0); end
    n_checks++; if (wr_addr.size() !== 256) begin n_fail++; $display("FAIL o16_count got %0d want 256", wr_addr.size()); end
    n_checks++; if (wr_addr.size() == 0 || wr_addr[0] !== 16'd8208) begin n_fail++; $display("FAIL o16_first_fb got %0d want 8208", wr_addr.size() ? wr_addr[0] : 16'hffff); end
    for (int k = 0; k < wr_addr.size() && k < 256; k++) begin
      dxk = k % 16; dyk = k / 16;
      n_checks++;
      if (wr_addr[k] !== 16'((32 + dyk) * 256 + 16 + dxk) ||
          wr_data[k] !== rom_val(14'((16 + dyk) * 128 + 32 + dxk), 2)) begin
        n_fail++;
        $display("FAIL o16_write%0d got addr %0d data %0d want addr %0d data %0d", k, wr_addr[k], wr_data[k],
                 (32 + dyk) * 256 + 16 + dxk, rom_val(14'((16 + dyk) * 128 + 32 + dxk), 2));
      end
    end
    @(negedge clk); en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_transparency;
    int dc, dxk, dyk;
    rom_mode = 1;
    start_tile(1'b1, 8'd40, 8'd8, 7'd0, 7'd0);
    wait_done(dc);
    n_checks++; if (dc !== e0 + 66) begin n_fail++; $display("FAIL tr_done_cycle got %0d want 66", dc - e0); end
    n_checks++; if (wr_addr.size() !== 32) begin n_fail++; $display("FAIL tr_count got %0d want 32", wr_addr.size()); end
    for (int j = 0; j < wr_addr.size() && j < 32; j++) begin
      dyk = j / 4; dxk = 2 * (j % 4) + 1;
      n_checks++;
      if (wr_addr[j] !== 16'((8 + dyk) * 256 + 40 + dxk) || wr_data[j] !== 4'd9) begin
        n_fail++;
        $display("FAIL tr_write%0d got addr %0d data %0d want addr %0d data 9", j, wr_addr[j], wr_data[j],
                 (8 + dyk) * 256 + 40 + dxk);
      end
    end
    @(negedge clk); en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clipping;
    int dc;
    rom_mode = 0;
    start_tile(1'b0, 8'd252, 8'd232, 7'd0, 7'd0);
    wait_done(dc);
    n_checks++; if (dc !== e0 + 258) begin n_fail++; $display("FAIL clip_done_cycle got %0d want 258", dc - e0); end
    n_checks++; if (wr_addr.size() !== 32) begin n_fail++; $display("FAIL clip_count got %0d want 32", wr_addr.size()); end
    for (int j = 0; j < wr_addr.size() && j < 32; j++) begin
      n_checks++;
      if (wr_addr[j] !== 16'((232 + j / 4) * 256 + 252 + j % 4)) begin
        n_fail++;
        $display("FAIL clip_write%0d got addr %0d want %0d", j, wr_addr[j], (232 + j / 4) * 256 + 252 + j % 4);
      end
    end
    @(negedge clk); en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_handshake_hold;
    int dc;
    logic [13:0] ra;
    rom_mode = 0;
    start_tile(1'b1, 8'd0, 8'd0, 7'd0, 7'd0);
    wait_done(dc);
    ra = rom_addr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || rom_addr !== ra || fb_we !== 1'b0) begin
        n_fail++;
        $display("FAIL hold%0d got done %b rom %0d we %b want done 1 rom %0d we 0", i, done, rom_addr, fb_we, ra);
      end
    end
    en = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL hold_done_fall got %b want 0", done); end
    start_tile(1'b1, 8'd0, 8'd0, 7'd3, 7'd5);
    @(negedge clk);
    n_checks++; if (rom_addr !== 14'd643) begin n_fail++; $display("FAIL hold_restart_rom got %0d want 643", rom_addr); end
    wait_done(dc);
    n_checks++; if (dc !== e0 + 66) begin n_fail++; $display("FAIL hold_restart_done got %0d want 66", dc - e0); end
    @(negedge clk); en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_early_drop;
    int dc;
    rom_mode = 0;
    start_tile(1'b1, 8'd100, 8'd50, 7'd0, 7'd0);
    repeat (5) @(negedge clk);
    en = 1'b0;
    wait_done(dc);
    n_checks++; if (dc !== e0 + 66) begin n_fail++; $display("FAIL drop_done_cycle got %0d want 66", dc - e0); end
    n_checks++; if (wr_addr.size() !== 64) begin n_fail++; $display("FAIL drop_count got %0d want 64", wr_addr.size()); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL drop_done_fall got %b want 0", done); end
  endtask

  task automatic test_reset_mid;
    int last;
    rom_mode = 0;
    start_tile(1'b1, 8'd0, 8'd0, 7'd0, 7'd0);
    repeat (21) @(negedge clk);
    n_checks++; if (rom_addr !== 14'd2 * 128 + 14'd4) begin n_fail++; $display("FAIL rmid_pixel20_rom got %0d want 260", rom_addr); end
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (done !== 1'b0 || fb_we !== 1'b0 || rom_addr !== 14'd0) begin
      n_fail++;
      $display("FAIL rmid_after got done %b we %b rom %0d want 0 0 0", done, fb_we, rom_addr);
    end
    repeat (80) @(negedge clk);
    n_checks++; if (wr_addr.size() !== 20) begin n_fail++; $display("FAIL rmid_count got %0d want 20", wr_addr.size()); end
    last = wr_cyc.size() ? wr_cyc[wr_cyc.size() - 1] - e0 : -1;
    n_checks++; if (last !== 21) begin n_fail++; $display("FAIL rmid_last_write got %0d want 21", last); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s8 = 1'b1;
    draw_x = 8'd0; draw_y = 8'd0; spr_x = 7'd0; spr_y = 7'd0;
    test_reset;
    test_opaque_8x8;
    test_offset_16x16;
    test_transparency;
    test_clipping;
    test_handshake_hold;
    test_early_drop;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_tile_blitter.md
# fb_tile_blitter

Framebuffer-side responder for the room tile drawer. It accepts one tile-draw request per `Draw_FB_EN` handshake and copies an 8x8 or 16x16 sprite from the synchronous sprite-sheet ROM into the framebuffer. Each pixel is a 4-bit palette index. The block skips transparent pixels and clips writes that fall off-screen, then raises `Done_Draw_FB` so the room drawer can advance to the next tile.

## Interface

Parameters:
- `FB_HEIGHT`, 240, visible framebuffer rows; framebuffer width is fixed at 256.

Ports:
- `Clk`  in  1  system clock; all state updates on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `Draw_FB_EN`  in  1  request; level held by the requester until `Done_Draw_FB` is seen
- `is_8`  in  1  tile size: 1 selects 8x8, 0 selects 16x16
- `NewDrawX`  in  8  framebuffer X of the tile's top-left pixel
- `NewDrawY`  in  8  framebuffer Y of the tile's top-left pixel
- `NewSpriteX`  in  7  sprite-sheet X of the source top-left pixel
- `NewSpriteY`  in  7  sprite-sheet Y of the source top-left pixel
- `rom_addr`  out  14  sprite ROM address, `{sy, sx}` = sy*128 + sx
- `rom_data`  in  4  ROM palette index; valid the cycle after `rom_addr` is presented
- `fb_we`  out  1  framebuffer write strobe
- `fb_addr`  out  16  framebuffer address, `{fy, fx}` = fy*256 + fx
- `fb_data`  out  4  palette index to write; equals `rom_data`
- `Done_Draw_FB`  out  1  tile finished; held high until the request drops

## Operation

States:
- **IDLE**
  - On `Draw_FB_EN`=1: latch `is_8`, `NewDrawX`, `NewDrawY`, `NewSpriteX`, `NewSpriteY`.
  - Clear the pixel counter and go to READ.
  - Inputs are not re-sampled until the block returns to IDLE.
- **READ**
  - Each cycle, present `rom_addr` for pixel `cnt` and increment `cnt`.
  - Counter is 8 bits. N = 64 for 8x8, 256 for 16x16.
  - Scan order is row-major with dx fastest: dx = `cnt` mod S, dy = `cnt` / S, where S = 8 or 16.
  - After issuing pixel N-1, go to DRAIN.
- **DRAIN**
  - One cycle, to complete the write of the last pixel.
  - Then go to DONE.
- **DONE**
  - `Done_Draw_FB`=1.
  - Stay here while `Draw_FB_EN`=1.
  - On `Draw_FB_EN`=0, go to IDLE.

Address arithmetic:
- Sprite: sx = `NewSpriteX` + dx and sy = `NewSpriteY` + dy, each 7-bit and wrapping mod 128 inside the sheet.
- Framebuffer: fx = `NewDrawX` + dx and fy = `NewDrawY` + dy, each computed to 9 bits.

Write pipeline:
- A one-stage valid/address register tracks each issued pixel, so its write lands in the cycle its `rom_data` is valid.
- `fb_we` = valid_d AND (`rom_data` != 0) AND (fx[8] == 0) AND (fy < `FB_HEIGHT`).
- `fb_addr` = `{fy[7:0], fx[7:0]}` from the delayed register.
- `fb_data` = `rom_data`.
- Palette index 0 is transparent and is never written.
- Clipped pixels are not written, but are still counted.

## Timing

Reset values (`RESET` sampled high at an edge):
- State is IDLE.
- `Done_Draw_FB`=0, `fb_we`=0, `rom_addr`=0, `fb_addr`=0, internal valid=0.
- Reset takes priority over all other transitions, including mid-READ and mid-DRAIN.
- After a mid-draw reset, no further `fb_we` is asserted for the aborted tile.

Cycle timing, with E0 = the edge that samples `Draw_FB_EN`=1 in IDLE:
- `rom_addr` for pixel k is valid in cycle E0+1+k.
- The write for pixel k occurs in cycle E0+2+k.
- The last write is in cycle E0+N+1.
- `Done_Draw_FB` first rises in cycle E0+N+2:
  - 8x8: 66 cycles after E0.
  - 16x16: 258 cycles after E0.

Handshake:
- `Done_Draw_FB` falls in the cycle after `Draw_FB_EN` is sampled low in DONE.
- A new request is accepted no earlier than the edge after the block returns to IDLE.
- `Draw_FB_EN` dropping during READ or DRAIN is ignored; the tile completes. DONE is then exited on the next edge, because `Draw_FB_EN` is already low.
- `Draw_FB_EN` held high continuously does not start a second draw until it has been seen low in DONE.

Maximum throughput: one pixel per clock.

## Test plan

- **8x8 opaque at origin.** `is_8`=1, Draw (0,0), Sprite (0,0), ROM returns 5 everywhere.
  -> 64 `fb_we` pulses with `fb_addr` 0..7, 256..263, …, 1792..1799, all `fb_data`=5; `Done_Draw_FB` rises at E0+66.
- **16x16 with sprite offset.** `is_8`=0, Draw (16,32), Sprite (32,16).
  -> first `rom_addr`=16*128+32=2080, first `fb_addr`=32*256+16=8208; 256 writes; Done at E0+258.
- **Transparency.** 8x8 tile where ROM returns 0 for every even dx.
  -> exactly 32 writes, none at even fx; Done timing unchanged.
- **Clipping.** 16x16 at Draw (252,232).
  -> writes only for fx 252..255 and fy 232..239, i.e. 32 writes; no write wraps to fx 0..11; Done still at E0+258.
- **Handshake hold.** Keep `Draw_FB_EN`=1 for 10 cycles after Done.
  -> Done stays high, no further `rom_addr` activity; drop `Draw_FB_EN` -> Done=0 next cycle; re-raise -> new draw starts.
- **Reset mid-draw.** Assert `RESET` for one edge while issuing pixel 20 of an 8x8 tile.
  -> next cycle: state IDLE, `fb_we`=0, Done=0; no writes for pixels ≥ 20 follow.
